// File: rtl/rule90_rewind.sv
// Rule 90 cellular automaton run backwards, one generation per clock.
// Ports: clk, resetn, start/data/steps (request), busy, done, q (state).
// Option: RULE90_REWIND_ZERO_STOP_EN ends a run early once q is all-zero.
module rule90_rewind #(
  parameter int WIDTH = 512,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] steps,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  if (WIDTH % 2 != 0) begin : g_bad_width
    $fatal(1, "rule90_rewind: WIDTH must be even");
  end

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] prev;
  logic             acc_o;
  logic             acc_e;
  logic             zero_cap;
  logic             zero_run;

  // Odd cells: prefix XOR of even cells from the bottom.
  // Even cells: suffix XOR of odd cells from the top.
  always_comb begin
    prev  = '0;
    acc_o = 1'b0;
    acc_e = 1'b0;
    for (int k = 0; k < WIDTH / 2; k++) begin
      acc_o = acc_o ^ q[2*k];
      prev[2*k+1] = acc_o;
    end
    for (int k = WIDTH / 2 - 1; k >= 0; k--) begin
      acc_e = acc_e ^ q[2*k+1];
      prev[2*k] = acc_e;
    end
  end

`ifdef RULE90_REWIND_ZERO_STOP_EN
  // All-zero is its own predecessor, so nothing is left to do.
  assign zero_cap = ~|data;
  assign zero_run = ~|q;
`else
  assign zero_cap = 1'b0;
  assign zero_run = 1'b0;
`endif

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt   <= '0;
      q     <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            q   <= data;
            cnt <= steps;
            if (steps == '0 || zero_cap) begin
              cnt  <= '0;
              done <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          q   <= prev;
          cnt <= cnt - 1'b1;
          if (zero_run) begin
            cnt   <= '0;
            state <= IDLE;
            done  <= 1'b1;
          end else if (cnt == CNT_W'(1)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rule90_rewind.sv
// Directed bench for rule90_rewind: hand vectors, forward-model
// round trips, start-while-busy, mid-run reset and zero input.
module tb_rule90_rewind;

  localparam int W = 512;
  localparam int C = 16;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] data = '0;
  logic [C-1:0] steps = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] q;

  int n_pass = 0;
  int n_tot  = 0;

  rule90_rewind #(.WIDTH(W), .CNT_W(C)) dut (
    .clk(clk), .resetn(resetn), .start(start),
    .data(data), .steps(steps),
    .busy(busy), .done(done), .q(q)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [W-1:0] got,
                       input logic [W-1:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [W-1:0] fwd(input logic [W-1:0] v);
    logic [W-1:0] n;
    n = '0;
    for (int i = 0; i < W; i++) begin
      n[i] = ((i + 1 < W) ? v[i+1] : 1'b0) ^ ((i > 0) ? v[i-1] : 1'b0);
    end
    return n;
  endfunction

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called at a negedge; request accepted at the next posedge.
  task automatic launch(input logic [W-1:0] d, input int s);
    start = 1'b1;
    data  = d;
    steps = C'(s);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns at the negedge where done is seen (or bound runs out).
  task automatic wait_done(input int lim, output int bc, output bit got);
    bc  = 0;
    got = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
    end
  endtask

  initial begin
    int bc;
    bit got;
    int dc;
    logic [W-1:0] v;
    logic [W-1:0] x;
    logic [W-1:0] aa;

    #12;
    check("rst_q", q, '0);
    check("rst_busy", W'(busy), '0);
    check("rst_done", W'(done), '0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // pred(1) = all odd cells set
    aa = {(W/2){2'b10}};
    launch(W'(1), 1);
    wait_done(20, bc, got);
    check("t1_done", W'(got), W'(1));
    check("t1_busy", W'(bc), W'(1));
    check("t1_q", q, aa);

    // 0x5 -> 0x2 -> 0x1
    @(negedge clk);
    check("t2_nodone", W'(done), '0);
    launch(W'(5), 2);
    @(negedge clk);
    check("t2_q0", q, W'(5));
    check("t2_b0", W'(busy), W'(1));
    @(negedge clk);
    check("t2_q1", q, W'(2));
    check("t2_b1", W'(busy), W'(1));
    @(negedge clk);
    check("t2_q2", q, W'(1));
    check("t2_b2", W'(busy), '0);
    check("t2_d2", W'(done), W'(1));
    @(negedge clk);
    check("t2_d3", W'(done), '0);

    // round trips against a forward model
    for (int s = 0; s < 20; s++) begin
      v = rnd();
      x = v;
      for (int g = 0; g < 100; g++) x = fwd(x);
      launch(x, 100);
      wait_done(300, bc, got);
      check($sformatf("rt%0d_q", s), q, v);
      check($sformatf("rt%0d_busy", s), W'(bc), W'(100));
    end

    // steps=0 then back-to-back start in the done cycle
    @(negedge clk);
    launch(W'(16'h1234), 0);
    wait_done(5, bc, got);
    check("z_done", W'(got), W'(1));
    check("z_busy", W'(bc), '0);
    check("z_q", q, W'(16'h1234));
    launch(W'(5), 2);
    wait_done(10, bc, got);
    check("b2b_done", W'(got), W'(1));
    check("b2b_busy", W'(bc), W'(2));
    check("b2b_q", q, W'(1));

    // start while busy is ignored
    @(negedge clk);
    v = rnd();
    x = v;
    for (int g = 0; g < 50; g++) x = fwd(x);
    launch(x, 50);
    bc  = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (busy) bc++;
      start = (bc == 10);
      data  = (bc == 10) ? W'(16'hffff) : x;
      steps = (bc == 10) ? C'(3) : C'(50);
    end
    start = 1'b0;
    check("ign_done", W'(got), W'(1));
    check("ign_busy", W'(bc), W'(50));
    check("ign_q", q, v);

    // asynchronous reset mid-run
    @(negedge clk);
    launch(rnd(), 50);
    repeat (20) @(negedge clk);
    check("mr_busy_pre", W'(busy), W'(1));
    resetn = 1'b0;
    #1;
    check("mr_q", q, '0);
    check("mr_busy", W'(busy), '0);
    check("mr_done", W'(done), '0);
    @(negedge clk);
    resetn = 1'b1;
    dc = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done || busy) dc++;
    end
    check("mr_nopulse", W'(dc), '0);

    // all-zero input
    launch('0, 1000);
    wait_done(2000, bc, got);
    check("zr_done", W'(got), W'(1));
`ifdef RULE90_REWIND_ZERO_STOP_EN
    check("zr_busy", W'(bc), '0);
`else
    check("zr_busy", W'(bc), W'(1000));
`endif
    check("zr_q", q, '0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/rule90_rewind.md
Name: rule90_rewind

Overview:
- Runs the Rule 90 cellular automaton backwards. Given a WIDTH-bit state, it computes the state from K generations earlier, at one generation per clock.
- The forward rule uses zero boundary cells: next[i] = q[i+1] ^ q[i-1], where q[-1] = q[WIDTH] = 0.
- For even WIDTH this rule is a bijection, so the predecessor is unique.
- The block sits beside the forward Rule 90 stepper. It reconstructs seed patterns and provides round-trip checking of the stepper.

Parameters:
- WIDTH, 512, cell count. Must be even; an odd value is a fatal elaboration error.
- CNT_W, 16, width of the generation-count input.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- resetn  input  1  asynchronous, active-low reset.
- start  input  1  request to rewind; sampled only while idle.
- data  input  WIDTH  starting state, captured when start is accepted.
- steps  input  CNT_W  number of generations to rewind, captured with data.
- busy  output  1  high while rewinding.
- done  output  1  one-cycle pulse when the result in q is final.
- q  output  WIDTH  current state.

Behaviour:
- Reset (resetn low, asynchronous): q=0, busy=0, done=0, internal counter=0. Reset takes effect immediately, including in the middle of a rewind; the run in progress is abandoned and there is no done pulse.
- Predecessor function pred(n), with N=WIDTH:
  - odd bits: p[2k+1] = XOR of n[0], n[2], ..., n[2k];
  - even bits: p[2k] = XOR of n[2k+1], n[2k+3], ..., n[N-1].
  - Implement as two prefix-XOR chains (ripple or tree, implementer's choice). It must settle in one cycle.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - done is a registered pulse, not a separate state.
- IDLE with start=1 at an edge:
  - q <= data; counter <= steps.
  - If steps==0: stay IDLE, done=1 for the next cycle. Latency is 1 cycle and q equals data.
  - If steps!=0: go to RUN, busy=1.
- RUN at each edge:
  - q <= pred(q); counter <= counter-1.
  - When the counter is 1 at the edge: go to IDLE, busy<=0, done<=1.
  - Total: busy is high for exactly K cycles, and done is high in the cycle after the K-th update.
- start while busy: ignored; data and steps are not captured.
- start in the same cycle as the done pulse: accepted, since the block is already IDLE. done drops and a new run begins, giving back-to-back operation.
- q holds its value in IDLE. done is 0 in every cycle other than the pulse cycle.
- steps = 2^CNT_W - 1 must complete without counter wrap.

Optional Feature:
- Macro: RULE90_REWIND_ZERO_STOP_EN.
- Defined: if q is all-zero during RUN, the run ends at that edge. The all-zero state is its own unique predecessor. busy<=0, done<=1, and the counter is cleared.
  - Also applies at capture: when data==0 and steps!=0, the block goes straight to the done pulse, like the steps==0 case.
- Undefined: the full count always runs.
- Final q is identical either way; only latency differs.

Test Plan:
- WIDTH=512; data=0x1; steps=1 -> busy 1 cycle, then done pulse. q = all odd bits set (0xAAAA...AAAA, 512 bits).
- data=0x5; steps=2 -> after the first update q=0x2, after the second q=0x1. busy high exactly 2 cycles, then a single done pulse.
- Round trip: load a random 512-bit vector v into a forward Rule 90 model, step it 100 times, and feed the result with steps=100 -> q==v at the done pulse. Repeat with 20 random seeds.
- steps=0 with data=0x1234 -> busy never rises, done high the next cycle, q=0x1234. A second start in the done cycle is accepted.
- Run with steps=50, assert start with new data at cycle 10 -> ignored, original run completes. Then pull resetn low at cycle 20 of a new run -> q=0, busy=0, done=0 immediately, no done pulse.
- data=0, steps=1000 -> with RULE90_REWIND_ZERO_STOP_EN, done in the cycle after capture and busy stays 0. Without the macro, busy stays high 1000 cycles. In both cases q=0.
